// File: rtl/fifo_pkg.sv
// Shared sizing for the package-parameterised FIFO: default data MSB,
// level-counter width helper and output-mode enumeration.
package fifo_pkg;

  parameter int unsigned DATA_MSB = 7;

  typedef enum logic {FIFO_FWFT, FIFO_REG} fifo_mode_e;

  function automatic int unsigned LVL_W(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pkg_fifo_ram.sv
// DEPTH x (DMSB+1) storage array: one synchronous write port, asynchronous read.
// Contents are deliberately not reset.
module pkg_fifo_ram #(
  parameter int unsigned DMSB  = fifo_pkg::DATA_MSB,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DMSB:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DMSB:0]            rdata
);

  logic [DMSB:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pkg_sized_fifo.sv
// Valid/ready FIFO with package-sized data, show-ahead or registered output.
// Optional almost_full output enabled by defining PKG_FIFO_AF_EN.
module pkg_sized_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DMSB   = fifo_pkg::DATA_MSB,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned FWFT   = 1,
  parameter int unsigned AF_LVL = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DMSB:0]              in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DMSB:0]              out_data,
  output logic [LVL_W(DEPTH)-1:0]    level
`ifdef PKG_FIFO_AF_EN
  ,
  output logic                       almost_full
`endif
);

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam int unsigned   LW       = LVL_W(DEPTH);
  localparam fifo_mode_e    MODE     = (FWFT != 0) ? FIFO_FWFT : FIFO_REG;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pkg_sized_fifo: DEPTH must be a power of two >= 2");
  end
  if (AF_LVL > DEPTH) begin : g_bad_af
    $error("pkg_sized_fifo: AF_LVL must not exceed DEPTH");
  end

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [DMSB:0] hold_q, hold_d, ram_rdata;
  logic          ovalid_q, ovalid_d;
  logic          push, pop, mem_rd;

  pkg_fifo_ram #(
    .DMSB  (DMSB),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  assign in_ready = (level_q != LVL_FULL);
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign level    = level_q;

  // hold_q is the last-popped word in show-ahead mode and the output stage
  // in registered mode; in registered mode level_q includes that stage.
  always_comb begin
    mem_rd    = 1'b0;
    hold_d    = hold_q;
    ovalid_d  = ovalid_q;
    out_valid = 1'b0;
    out_data  = hold_q;
    if (MODE == FIFO_FWFT) begin
      out_valid = (level_q != '0);
      out_data  = out_valid ? ram_rdata : hold_q;
      mem_rd    = pop;
      if (pop) begin
        hold_d = ram_rdata;
      end
    end else begin
      out_valid = ovalid_q;
      mem_rd    = (!ovalid_q || pop) && (level_q > LW'(ovalid_q));
      if (mem_rd) begin
        hold_d   = ram_rdata;
        ovalid_d = 1'b1;
      end else if (pop) begin
        ovalid_d = 1'b0;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(mem_rd);
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      hold_q   <= '0;
      ovalid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      hold_q   <= hold_d;
      ovalid_q <= ovalid_d;
    end
  end

`ifdef PKG_FIFO_AF_EN
  logic af_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      af_q <= 1'b0;
    end else begin
      af_q <= (level_d >= LW'(AF_LVL));
    end
  end

  assign almost_full = af_q;
`endif

endmodule

// File: tb/tb_pkg_sized_fifo.sv
// Directed self-checking bench: default show-ahead instance (A) and a
// 16-bit registered-output instance (B). Define PKG_FIFO_AF_EN for almost_full.
module tb_pkg_sized_fifo;
  import fifo_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned LW    = LVL_W(DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [DATA_MSB:0] a_in_data, a_out_data;
  logic [LW-1:0]     a_level;
  logic              b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0]       b_in_data, b_out_data;
  logic [LW-1:0]     b_level;
`ifdef PKG_FIFO_AF_EN
  logic              a_af, b_af;
`endif

  int nvec = 0;
  int nerr = 0;

  pkg_sized_fifo #(
    .DEPTH (DEPTH)
  ) u_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .level     (a_level)
`ifdef PKG_FIFO_AF_EN
    ,
    .almost_full (a_af)
`endif
  );

  pkg_sized_fifo #(
    .DMSB  (15),
    .DEPTH (DEPTH),
    .FWFT  (0)
  ) u_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .level     (b_level)
`ifdef PKG_FIFO_AF_EN
    ,
    .almost_full (b_af)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
    tick();
    tick();
    rst = 1'b0;

    // 1: reset with traffic in flight
    a_in_valid = 1'b1; a_in_data = 8'h55;
    tick();
    tick();
    chk("pre_rst_level", 32'(a_level), 32'd2);
    rst = 1'b1;
    tick();
    chk("rst_a_level",     32'(a_level),     32'd0);
    chk("rst_a_in_ready",  32'(a_in_ready),  32'd1);
    chk("rst_a_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_a_out_data",  32'(a_out_data),  32'd0);
    chk("rst_b_level",     32'(b_level),     32'd0);
    chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    chk("rst_b_out_data",  32'(b_out_data),  32'd0);
    rst = 1'b0;
    a_in_valid = 1'b0;
    tick();
    chk("post_rst_level", 32'(a_level), 32'd0);

    // 2: fill A, reject overflow, drain in order
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1'b1; a_in_data = 8'(i);
      tick();
    end
    chk("fill_level",    32'(a_level),    32'd8);
    chk("fill_in_ready", 32'(a_in_ready), 32'd0);
    a_in_data = 8'h09;
    tick();
    a_in_valid = 1'b0;
    chk("ovf_level", 32'(a_level),    32'd8);
    chk("ovf_head",  32'(a_out_data), 32'h01);
    a_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_valid", 32'(a_out_valid), 32'd1);
      chk("drain_data",  32'(a_out_data),  32'(i));
      tick();
    end
    a_out_ready = 1'b0;
    chk("drain_empty", 32'(a_out_valid), 32'd0);
    chk("empty_hold",  32'(a_out_data),  32'h08);
    chk("empty_level", 32'(a_level),     32'd0);

    // 3: simultaneous push/pop at level 4
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1; a_in_data = 8'(8'h10 + i);
      tick();
    end
    chk("sim_start_level", 32'(a_level), 32'd4);
    a_out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      a_in_data = 8'(8'h14 + k);
      chk("sim_data", 32'(a_out_data), 32'(8'h10 + k));
      tick();
    end
    a_in_valid = 1'b0;
    chk("sim_end_level", 32'(a_level), 32'd4);
    for (int k = 20; k < 24; k++) begin
      chk("sim_tail", 32'(a_out_data), 32'(8'h10 + k));
      tick();
    end
    a_out_ready = 1'b0;
    chk("sim_empty", 32'(a_out_valid), 32'd0);

    // 4: show-ahead latency
    a_in_valid = 1'b1; a_in_data = 8'hA5;
    #1;
    chk("lat_a_before", 32'(a_out_valid), 32'd0);
    tick();
    a_in_valid = 1'b0;
    chk("lat_a_valid", 32'(a_out_valid), 32'd1);
    chk("lat_a_data",  32'(a_out_data),  32'hA5);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    chk("lat_a_popped", 32'(a_level), 32'd0);

    // 4/5: registered latency and 16-bit round trip on B
    b_in_valid = 1'b1; b_in_data = 16'hBEEF;
    tick();
    b_in_valid = 1'b0;
    chk("lat_b_cycle1", 32'(b_out_valid), 32'd0);
    chk("lat_b_level1", 32'(b_level),     32'd1);
    tick();
    chk("lat_b_valid", 32'(b_out_valid), 32'd1);
    chk("lat_b_data",  32'(b_out_data),  32'hBEEF);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    chk("lat_b_empty", 32'(b_out_valid), 32'd0);
    chk("lat_b_hold",  32'(b_out_data),  32'hBEEF);

    // 2 on B: full counts the output stage
    for (int i = 1; i <= 8; i++) begin
      b_in_valid = 1'b1; b_in_data = 16'(16'h1000 + i);
      tick();
    end
    chk("b_full_level", 32'(b_level),    32'd8);
    chk("b_full_ready", 32'(b_in_ready), 32'd0);
    b_in_data = 16'h1009;
    tick();
    b_in_valid = 1'b0;
    chk("b_ovf_level", 32'(b_level),    32'd8);
    chk("b_stable",    32'(b_out_data), 32'h1001);
    b_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("b_drain_valid", 32'(b_out_valid), 32'd1);
      chk("b_drain_data",  32'(b_out_data),  32'(16'h1000 + i));
      tick();
    end
    b_out_ready = 1'b0;
    chk("b_drain_empty", 32'(b_out_valid), 32'd0);
    chk("b_drain_level", 32'(b_level),     32'd0);

`ifdef PKG_FIFO_AF_EN
    // 6: almost_full at AF_LVL = 6
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 1'b1; a_in_data = 8'(8'h30 + i);
      tick();
    end
    chk("af_at5", 32'(a_af), 32'd0);
    a_in_data = 8'h35;
    tick();
    a_in_valid = 1'b0;
    chk("af_at6", 32'(a_af), 32'd1);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    chk("af_pop", 32'(a_af), 32'd0);
`endif

    $display("*-* All Finished *-*");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
